// File: rtl/i2c_slave_pkg.sv
// Shared types for the I2C target: FSM states and ACK bit levels.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Pad conditioning for one I2C line: 2-FF synchronizer, run-length glitch
// filter and single-cycle edge pulses on the filtered level.
module i2c_in_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Presets model an idle (pulled-up) bus so reset never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b11;
      lvl  <= 1'b1;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        lvl  <= sync[1];
        cnt  <= '0;
        rise <= sync[1];
        fall <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target exposing an 8-bit pointer-addressed register window.
// No clock stretching; SDA is driven open-drain through sda_oe.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter int         FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .din(scl_i),
    .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .din(sda_i),
    .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_e state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw;
  logic       inc_pend;
  logic [7:0] byte_in;

  assign byte_in = {shreg[6:0], sda_lvl};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      inc_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      // Post-write increment lands the cycle after the strobe, independent of bus events.
      if (inc_pend) begin
        reg_addr <= reg_addr + 8'd1;
        inc_pend <= 1'b0;
      end

      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (byte_in[7:1] == DEV_ADDR) rw <= byte_in[0];
                else                          state <= ST_IGNORE;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= ST_ADDR_ACK;
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              busy    <= 1'b1;
              bit_cnt <= '0;
              if (rw) begin
                shreg    <= reg_rdata;
                reg_addr <= reg_addr + 8'd1;
                sda_oe   <= ~reg_rdata[7];
                state    <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_PTR;
              end
            end
          end

          ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (state == ST_PTR) begin
                  reg_addr <= byte_in;
                end else begin
                  reg_wdata <= byte_in;
                  reg_we    <= 1'b1;
                  inc_pend  <= 1'b1;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= (state == ST_PTR) ? ST_PTR_ACK : ST_WDATA_ACK;
            end
          end

          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_WDATA;
            end
          end

          // bit_cnt counts bits already driven after bit7; the 8th fall hands SDA back.
          ST_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe <= 1'b0;
                state  <= ST_RDATA_ACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_oe  <= ~shreg[6];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ST_RDATA_ACK: begin
            if (scl_rise && sda_lvl == I2C_NACK) begin
              state <= ST_IGNORE;
            end else if (scl_fall) begin
              shreg    <= reg_rdata;
              reg_addr <= reg_addr + 8'd1;
              sda_oe   <= ~reg_rdata[7];
              bit_cnt  <= '0;
              state    <= ST_RDATA;
            end
          end

          ST_IDLE, ST_IGNORE: sda_oe <= 1'b0;

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bus-level master tasks, a register-file model and a
// pointer/memory reference model checked per scenario.
module tb_i2c_slave;

  localparam int Q = 10;  // clk cycles per quarter SCL period
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_i = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_i;
  logic       sda_oe, reg_we, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  int tests_run = 0;
  int failed = 0;

  logic [7:0]  rf [256];
  bit          rf_ready = 1'b0;
  logic [7:0]  mm [256];
  int unsigned mptr = 0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int          obs_rd = 0;
  int          oe_cnt = 0;

  assign sda_i     = m_sda & ~sda_oe;
  assign reg_rdata = rf[reg_addr];

  always #5 clk = ~clk;

  i2c_slave #(.DEV_ADDR(7'h42), .FILTER_LEN(4)) dut (
    .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  // Register file behind the target plus write/drive observation.
  always @(negedge clk) begin
    if (!rf_ready) begin
      for (int i = 0; i < 256; i++) rf[i] = ~8'(i);
      rf_ready = 1'b1;
    end
    if (reg_we === 1'b1) begin
      obs_q.push_back({reg_addr, reg_wdata});
      rf[reg_addr] = reg_wdata;
    end
    if (sda_oe === 1'b1) oe_cnt++;
  end

  task automatic hp();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; scl_i = 1'b1; hp(); hp();
    m_sda = 1'b0; hp(); hp();
    scl_i = 1'b0;
  endtask

  task automatic i2c_rep_start();
    hp(); m_sda = 1'b1; hp(); scl_i = 1'b1; hp(); hp();
    m_sda = 1'b0; hp(); hp();
    scl_i = 1'b0;
  endtask

  task automatic i2c_stop();
    hp(); m_sda = 1'b0; hp(); scl_i = 1'b1; hp(); hp();
    m_sda = 1'b1; hp(); hp();
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      hp(); m_sda = b[i]; hp(); scl_i = 1'b1;
      if (glitch && i == 7) begin
        hp(); m_sda = ~m_sda; repeat (2) @(negedge clk); m_sda = ~m_sda; hp();
      end else begin
        hp(); hp();
      end
      scl_i = 1'b0;
    end
    hp(); m_sda = 1'b1; hp(); scl_i = 1'b1; hp(); ack = sda_i; hp(); scl_i = 1'b0;
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      hp(); m_sda = 1'b1; hp(); scl_i = 1'b1; hp(); d[i] = sda_i; hp(); scl_i = 1'b0;
    end
    hp(); m_sda = ack; hp(); scl_i = 1'b1; hp(); hp(); scl_i = 1'b0;
  endtask

  // Full write transaction; the model records the writes it implies.
  task automatic bus_write(input logic [7:0] ptr, input bq_t d, output int nacks);
    bit a;
    nacks = 0;
    i2c_start();
    write_byte(8'h84, 1'b0, a); nacks += int'(a);
    write_byte(ptr, 1'b0, a);   nacks += int'(a);
    mptr = ptr;
    foreach (d[k]) begin
      write_byte(d[k], 1'b0, a); nacks += int'(a);
      exp_q.push_back({8'(mptr), d[k]});
      mm[mptr] = d[k];
      mptr = (mptr + 1) % 256;
    end
    i2c_stop();
  endtask

  task automatic bus_read(input int n, output bq_t got, output int nacks);
    bit a;
    logic [7:0] b;
    got = {};
    i2c_start();
    write_byte(8'h85, 1'b0, a); nacks = int'(a);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, b);
      got.push_back(b);
    end
    i2c_stop();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (sda_oe !== 1'b0) begin failed++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
    tests_run++; if (reg_we !== 1'b0) begin failed++; $display("FAIL reset_reg_we got %b exp 0", reg_we); end
    tests_run++; if (reg_wdata !== 8'h00) begin failed++; $display("FAIL reset_reg_wdata got %h exp 00", reg_wdata); end
    tests_run++; if (reg_addr !== 8'h00) begin failed++; $display("FAIL reset_reg_addr got %h exp 00", reg_addr); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b1;
    hp();
  endtask

  task automatic test_burst_write();
    bit a;
    int nacks = 0;
    i2c_start();
    write_byte(8'h84, 1'b0, a); nacks += int'(a);
    write_byte(8'h10, 1'b0, a); nacks += int'(a);
    write_byte(8'hA5, 1'b0, a); nacks += int'(a);
    tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL burst_busy_mid got %b exp 1", busy); end
    write_byte(8'h5A, 1'b0, a); nacks += int'(a);
    i2c_stop();
    hp();
    exp_q.push_back(16'h10A5); exp_q.push_back(16'h115A);
    mm[8'h10] = 8'hA5; mm[8'h11] = 8'h5A; mptr = 8'h12;
    tests_run++; if (nacks != 0) begin failed++; $display("FAIL burst_acks got %0d nacks exp 0", nacks); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL burst_busy_stop got %b exp 0", busy); end
    while (exp_q.size() > 0) begin
      logic [15:0] e = exp_q.pop_front();
      tests_run++;
      if (obs_rd >= obs_q.size()) begin failed++; $display("FAIL burst_we missing exp %h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin failed++; $display("FAIL burst_we got %h exp %h", obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    tests_run++; if (reg_addr !== 8'h12) begin failed++; $display("FAIL burst_ptr got %h exp 12", reg_addr); end
  endtask

  task automatic test_combined_read();
    bit a;
    int nacks = 0;
    logic [7:0] d0, d1;
    int wr0 = obs_q.size();
    i2c_start();
    write_byte(8'h84, 1'b0, a); nacks += int'(a);
    write_byte(8'h20, 1'b0, a); nacks += int'(a);
    i2c_rep_start();
    write_byte(8'h85, 1'b0, a); nacks += int'(a);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop();
    hp();
    mptr = 8'h22;
    tests_run++; if (nacks != 0) begin failed++; $display("FAIL comb_acks got %0d nacks exp 0", nacks); end
    tests_run++; if (d0 !== 8'hDF) begin failed++; $display("FAIL comb_byte0 got %h exp DF", d0); end
    tests_run++; if (d1 !== 8'hDE) begin failed++; $display("FAIL comb_byte1 got %h exp DE", d1); end
    tests_run++; if (reg_addr !== 8'h22) begin failed++; $display("FAIL comb_ptr got %h exp 22", reg_addr); end
    tests_run++; if (obs_q.size() != wr0) begin failed++; $display("FAIL comb_no_we got %0d writes exp 0", obs_q.size() - wr0); end
  endtask

  task automatic test_addr_mismatch();
    bit a0, a1;
    int oe0 = oe_cnt;
    int wr0 = obs_q.size();
    i2c_start();
    write_byte(8'h86, 1'b0, a0);
    write_byte(8'hFF, 1'b0, a1);
    i2c_stop();
    hp();
    tests_run++; if (a0 !== 1'b1) begin failed++; $display("FAIL mis_addr_ack got %b exp 1", a0); end
    tests_run++; if (oe_cnt != oe0) begin failed++; $display("FAIL mis_sda_oe got %0d drive cycles exp 0", oe_cnt - oe0); end
    tests_run++; if (obs_q.size() != wr0) begin failed++; $display("FAIL mis_no_we got %0d writes exp 0", obs_q.size() - wr0); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL mis_busy got %b exp 0", busy); end
  endtask

  task automatic test_wrap_retention();
    int nacks;
    bq_t got;
    logic [7:0] e;
    bus_write(8'hFF, '{8'h11, 8'h22}, nacks);
    hp();
    tests_run++; if (nacks != 0) begin failed++; $display("FAIL wrap_acks got %0d nacks exp 0", nacks); end
    while (exp_q.size() > 0) begin
      logic [15:0] x = exp_q.pop_front();
      tests_run++;
      if (obs_rd >= obs_q.size()) begin failed++; $display("FAIL wrap_we missing exp %h", x); end
      else begin
        if (obs_q[obs_rd] !== x) begin failed++; $display("FAIL wrap_we got %h exp %h", obs_q[obs_rd], x); end
        obs_rd++;
      end
    end
    e = mm[mptr];
    mptr = (mptr + 1) % 256;
    bus_read(1, got, nacks);
    hp();
    tests_run++; if (got[0] !== 8'hFE || got[0] !== e) begin failed++; $display("FAIL wrap_read got %h exp FE", got[0]); end
    tests_run++; if (reg_addr !== 8'h02) begin failed++; $display("FAIL wrap_ptr got %h exp 02", reg_addr); end
  endtask

  task automatic test_glitch();
    bit a;
    int nacks = 0;
    int oe0 = oe_cnt;
    m_sda = 1'b0; repeat (2) @(negedge clk); m_sda = 1'b1;
    hp(); scl_i = 1'b0;
    write_byte(8'h84, 1'b0, a);
    i2c_stop();
    tests_run++; if (a !== 1'b1) begin failed++; $display("FAIL glitch_start_ack got %b exp 1", a); end
    tests_run++; if (oe_cnt != oe0) begin failed++; $display("FAIL glitch_start_oe got %0d drive cycles exp 0", oe_cnt - oe0); end
    i2c_start();
    write_byte(8'h84, 1'b0, a); nacks += int'(a);
    write_byte(8'h30, 1'b0, a); nacks += int'(a);
    write_byte(8'h3C, 1'b1, a); nacks += int'(a);
    write_byte(8'h4D, 1'b0, a); nacks += int'(a);
    i2c_stop();
    hp();
    exp_q.push_back(16'h303C); exp_q.push_back(16'h314D);
    mm[8'h30] = 8'h3C; mm[8'h31] = 8'h4D; mptr = 8'h32;
    tests_run++; if (nacks != 0) begin failed++; $display("FAIL glitch_stop_acks got %0d nacks exp 0", nacks); end
    while (exp_q.size() > 0) begin
      logic [15:0] x = exp_q.pop_front();
      tests_run++;
      if (obs_rd >= obs_q.size()) begin failed++; $display("FAIL glitch_we missing exp %h", x); end
      else begin
        if (obs_q[obs_rd] !== x) begin failed++; $display("FAIL glitch_we got %h exp %h", obs_q[obs_rd], x); end
        obs_rd++;
      end
    end
  endtask

  task automatic test_reset_midread();
    bit a;
    int nacks;
    bq_t none;
    none = {};
    bus_write(8'h90, '{8'h33}, nacks);
    exp_q.delete();
    obs_rd = obs_q.size();
    i2c_start();
    write_byte(8'h85, 1'b0, a);
    hp();
    tests_run++; if (sda_oe !== ~mm[mptr][7]) begin failed++; $display("FAIL rst_drive_bit7 got %b exp %b", sda_oe, ~mm[mptr][7]); end
    reset = 1'b0;
    #1;
    tests_run++; if (sda_oe !== 1'b0) begin failed++; $display("FAIL rst_async_release got %b exp 0", sda_oe); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_async_busy got %b exp 0", busy); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mptr = 0;
    nacks = 0;
    i2c_rep_start();
    write_byte(8'h84, 1'b0, a); nacks += int'(a);
    write_byte(8'h50, 1'b0, a); nacks += int'(a);
    write_byte(8'h77, 1'b0, a); nacks += int'(a);
    i2c_stop();
    hp();
    mm[8'h50] = 8'h77; mptr = 8'h51;
    tests_run++; if (nacks != 0) begin failed++; $display("FAIL rst_recover_acks got %0d nacks exp 0", nacks); end
    tests_run++;
    if (obs_q.size() != obs_rd + 1 || obs_q[obs_rd] !== 16'h5077) begin
      failed++; $display("FAIL rst_recover_we got %0d writes last %h exp 1 write 5077", obs_q.size() - obs_rd, obs_q[obs_q.size()-1]);
    end
    obs_rd = obs_q.size();
    tests_run++; if (reg_addr !== 8'h51) begin failed++; $display("FAIL rst_recover_ptr got %h exp 51", reg_addr); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int nacks;
      if ($urandom_range(0, 1) == 1) begin
        bq_t d;
        logic [7:0] ptr = 8'($urandom);
        int n = $urandom_range(1, 4);
        d = {};
        for (int k = 0; k < n; k++) d.push_back(8'($urandom));
        bus_write(ptr, d, nacks);
        hp();
        tests_run++; if (nacks != 0) begin failed++; $display("FAIL rnd_w%0d_acks got %0d nacks exp 0", t, nacks); end
        while (exp_q.size() > 0) begin
          logic [15:0] x = exp_q.pop_front();
          tests_run++;
          if (obs_rd >= obs_q.size()) begin failed++; $display("FAIL rnd_w%0d_we missing exp %h", t, x); end
          else begin
            if (obs_q[obs_rd] !== x) begin failed++; $display("FAIL rnd_w%0d_we got %h exp %h", t, obs_q[obs_rd], x); end
            obs_rd++;
          end
        end
      end else begin
        bq_t got, exp_d;
        int n = $urandom_range(1, 3);
        int wr0 = obs_q.size();
        exp_d = {};
        for (int k = 0; k < n; k++) begin
          exp_d.push_back(mm[mptr]);
          mptr = (mptr + 1) % 256;
        end
        bus_read(n, got, nacks);
        hp();
        tests_run++; if (nacks != 0) begin failed++; $display("FAIL rnd_r%0d_addr_ack got nack exp ack", t); end
        for (int k = 0; k < n; k++) begin
          tests_run++;
          if (got[k] !== exp_d[k]) begin failed++; $display("FAIL rnd_r%0d_byte%0d got %h exp %h", t, k, got[k], exp_d[k]); end
        end
        tests_run++; if (obs_q.size() != wr0) begin failed++; $display("FAIL rnd_r%0d_no_we got %0d writes exp 0", t, obs_q.size() - wr0); end
      end
      tests_run++; if (reg_addr !== 8'(mptr)) begin failed++; $display("FAIL rnd_%0d_ptr got %h exp %h", t, reg_addr, 8'(mptr)); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = ~8'(i);
    test_reset();
    test_burst_write();
    test_combined_read();
    test_addr_mismatch();
    test_wrap_retention();
    test_glitch();
    test_reset_midread();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
